// File: rtl/csr_timer_compare.sv
// 64-bit timer compare CSR block: staged 64-bit compare register, 32-bit period,
// and a sticky interrupt raised when the timer reaches compare, with optional periodic re-arm.
module csr_timer_compare #(
    parameter logic [11:0] ADDRESS_LOWER   = 12'h000,
    parameter logic [11:0] ADDRESS_UPPER   = 12'h000,
    parameter logic [11:0] ADDRESS_PERIOD  = 12'h000,
    parameter logic [11:0] ADDRESS_CONTROL = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csrWriteEnable,
    input  logic [11:0] csrWriteAddress,
    input  logic [31:0] csrWriteData,
    input  logic        csrReadEnable,
    input  logic [11:0] csrReadAddress,
    output logic [31:0] csrReadData,
    output logic        csrRequestOutput,
    input  logic [63:0] timerValue,
    output logic        timerInterrupt
);

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_PENDING  = 1;
    localparam int CTRL_PERIODIC = 2;

    logic [63:0] compare_q, compare_d;
    logic [31:0] lower_shadow_q, lower_shadow_d;
    logic [31:0] period_q, period_d;
    logic        enable_q, enable_d;
    logic        periodic_q, periodic_d;
    logic        pending_q, pending_d;

    logic write_lower, write_upper, write_period, write_control;
    logic match;

    assign write_lower   = csrWriteEnable && (csrWriteAddress == ADDRESS_LOWER);
    assign write_upper   = csrWriteEnable && (csrWriteAddress == ADDRESS_UPPER);
    assign write_period  = csrWriteEnable && (csrWriteAddress == ADDRESS_PERIOD);
    assign write_control = csrWriteEnable && (csrWriteAddress == ADDRESS_CONTROL);

    // Compare against the committed register only, so a half-written compare never matches.
    assign match = enable_q && (timerValue >= compare_q);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        compare_d      = compare_q;
        lower_shadow_d = lower_shadow_q;
        period_d       = period_q;
        enable_d       = enable_q;
        periodic_d     = periodic_q;
        pending_d      = pending_q;

        if (match && periodic_q) begin
            compare_d = compare_q + {32'b0, period_q};
        end
        // A software commit of the upper half overrides the periodic advance.
        if (write_upper) begin
            compare_d = {csrWriteData, lower_shadow_q};
        end
        if (write_lower) begin
            lower_shadow_d = csrWriteData;
        end
        if (write_period) begin
            period_d = csrWriteData;
        end
        if (write_control) begin
            enable_d   = csrWriteData[CTRL_ENABLE];
            periodic_d = csrWriteData[CTRL_PERIODIC];
            if (csrWriteData[CTRL_PENDING]) begin
                pending_d = 1'b0;
            end
        end
        // Hardware set beats write-1-to-clear in the same cycle.
        if (match) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_q      <= 64'hFFFF_FFFF_FFFF_FFFF;
            lower_shadow_q <= '0;
            period_q       <= '0;
            enable_q       <= 1'b0;
            periodic_q     <= 1'b0;
            pending_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            compare_q      <= compare_d;
            lower_shadow_q <= lower_shadow_d;
            period_q       <= period_d;
            enable_q       <= enable_d;
            periodic_q     <= periodic_d;
            pending_q      <= pending_d;
        end
    end

    always_comb begin
        csrReadData      = '0;
        csrRequestOutput = 1'b0;
        if (csrReadEnable) begin
            if (csrReadAddress == ADDRESS_LOWER) begin
                csrReadData      = compare_q[31:0];
                csrRequestOutput = 1'b1;
            end else if (csrReadAddress == ADDRESS_UPPER) begin
                csrReadData      = compare_q[63:32];
                csrRequestOutput = 1'b1;
            end else if (csrReadAddress == ADDRESS_PERIOD) begin
                csrReadData      = period_q;
                csrRequestOutput = 1'b1;
            end else if (csrReadAddress == ADDRESS_CONTROL) begin
                csrReadData      = {29'b0, periodic_q, pending_q, enable_q};
                csrRequestOutput = 1'b1;
            end
        end
    end

    assign timerInterrupt = pending_q;

endmodule

// File: tb/tb_csr_timer_compare.sv
// Scoreboard bench for csr_timer_compare: reads push expected data/irq into a queue,
// a negedge monitor pops and compares whenever the block drives the read bus.
module tb_csr_timer_compare;

    localparam logic [11:0] A_LO  = 12'h7C0;
    localparam logic [11:0] A_HI  = 12'h7C1;
    localparam logic [11:0] A_PER = 12'h7C2;
    localparam logic [11:0] A_CTL = 12'h7C3;

    logic        clk = 1'b0;
    logic        rst;
    logic        csrWriteEnable;
    logic [11:0] csrWriteAddress;
    logic [31:0] csrWriteData;
    logic        csrReadEnable;
    logic [11:0] csrReadAddress;
    logic [31:0] csrReadData;
    logic        csrRequestOutput;
    logic [63:0] timerValue;
    logic        timerInterrupt;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    csr_timer_compare #(
        .ADDRESS_LOWER  (A_LO),
        .ADDRESS_UPPER  (A_HI),
        .ADDRESS_PERIOD (A_PER),
        .ADDRESS_CONTROL(A_CTL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .csrWriteEnable  (csrWriteEnable),
        .csrWriteAddress (csrWriteAddress),
        .csrWriteData    (csrWriteData),
        .csrReadEnable   (csrReadEnable),
        .csrReadAddress  (csrReadAddress),
        .csrReadData     (csrReadData),
        .csrRequestOutput(csrRequestOutput),
        .timerValue      (timerValue),
        .timerInterrupt  (timerInterrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (csrRequestOutput) begin
            if (sb_q.size() == 0) begin
                check("unexpected_read", 64'(csrReadData), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_data"}, 64'(csrReadData), 64'(e.data));
                check({e.name, "_irq"}, 64'(timerInterrupt), 64'(e.irq));
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csrWriteEnable  = 1'b1;
        csrWriteAddress = addr;
        csrWriteData    = data;
        @(posedge clk);
        #1;
        csrWriteEnable  = 1'b0;
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp_data,
                      input logic exp_irq, input string name);
        exp_t e;
        e.name = name;
        e.data = exp_data;
        e.irq  = exp_irq;
        sb_q.push_back(e);
        csrReadEnable  = 1'b1;
        csrReadAddress = addr;
        @(posedge clk);
        #1;
        csrReadEnable  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        csrWriteEnable  = 1'b0;
        csrWriteAddress = '0;
        csrWriteData    = '0;
        csrReadEnable   = 1'b0;
        csrReadAddress  = '0;
        timerValue      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("irq_in_reset", 64'(timerInterrupt), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset values
        rd(A_LO,  32'hFFFF_FFFF, 1'b0, "rst_lower");
        rd(A_HI,  32'hFFFF_FFFF, 1'b0, "rst_upper");
        rd(A_PER, 32'h0,         1'b0, "rst_period");
        rd(A_CTL, 32'h0,         1'b0, "rst_control");

        // Unmapped address: bus must stay quiet
        csrReadEnable  = 1'b1;
        csrReadAddress = 12'h123;
        #1;
        check("unmapped_req", 64'(csrRequestOutput), 64'd0);
        check("unmapped_data", 64'(csrReadData), 64'd0);
        @(posedge clk);
        #1;
        csrReadEnable = 1'b0;

        // One-shot match with latency of one cycle
        wr(A_LO, 32'h10);
        wr(A_HI, 32'h0);
        wr(A_CTL, 32'h1);
        for (int t = 0; t <= 16; t++) begin
            timerValue = 64'(t);
            rd(A_CTL, 32'h1, 1'b0, "ramp_ctrl");
        end
        rd(A_CTL, 32'h3, 1'b1, "ramp_fired");
        timerValue = 64'h5;
        wr(A_CTL, 32'h3);
        rd(A_CTL, 32'h1, 1'b0, "w1c_cleared");

        // Staged lower half does not affect compare until upper commits
        do_reset();
        timerValue = 64'h0;
        wr(A_CTL, 32'h1);
        wr(A_LO, 32'h20);
        rd(A_LO, 32'hFFFF_FFFF, 1'b0, "staged_lower");
        timerValue = 64'h20;
        rd(A_CTL, 32'h1, 1'b0, "staged_nomatch0");
        rd(A_CTL, 32'h1, 1'b0, "staged_nomatch1");
        wr(A_HI, 32'h0);
        rd(A_LO, 32'h20, 1'b0, "committed_lower");
        rd(A_CTL, 32'h3, 1'b1, "committed_fire");

        // Periodic advance
        do_reset();
        wr(A_LO, 32'h100);
        wr(A_HI, 32'h0);
        wr(A_PER, 32'h40);
        rd(A_PER, 32'h40, 1'b0, "period_rd");
        timerValue = 64'hFF;
        wr(A_CTL, 32'h5);
        rd(A_CTL, 32'h5, 1'b0, "per_armed");
        timerValue = 64'h100;
        rd(A_LO, 32'h100, 1'b0, "per_cmp0");
        rd(A_LO, 32'h140, 1'b1, "per_cmp1");
        timerValue = 64'h140;
        rd(A_LO, 32'h140, 1'b1, "per_cmp1b");
        rd(A_LO, 32'h180, 1'b1, "per_cmp2");
        rd(A_CTL, 32'h7, 1'b1, "per_sticky");
        wr(A_CTL, 32'h7);
        rd(A_CTL, 32'h5, 1'b0, "per_w1c");

        // Period zero: compare holds, pending re-set while matching
        wr(A_PER, 32'h0);
        timerValue = 64'h180;
        rd(A_LO, 32'h180, 1'b0, "p0_cmp");
        rd(A_LO, 32'h180, 1'b1, "p0_hold");
        wr(A_CTL, 32'h7);
        rd(A_CTL, 32'h7, 1'b1, "p0_set_beats_w1c");

        // 64-bit wrap, W1C colliding with match, upper write beating periodic advance
        do_reset();
        wr(A_LO, 32'hFFFF_FFF0);
        wr(A_HI, 32'hFFFF_FFFF);
        wr(A_PER, 32'h20);
        timerValue = 64'hFFFF_FFFF_FFFF_FFF0;
        wr(A_CTL, 32'h5);
        wr(A_CTL, 32'h7);
        rd(A_LO, 32'h10, 1'b1, "wrap_lo0");
        rd(A_LO, 32'h30, 1'b1, "wrap_lo1");
        rd(A_HI, 32'h0,  1'b1, "wrap_hi");
        wr(A_LO, 32'h1234);
        wr(A_HI, 32'h1);
        rd(A_HI, 32'h1,    1'b1, "upper_wins_hi");
        rd(A_LO, 32'h1254, 1'b1, "upper_wins_lo");

        // Disable on the same edge as a match still sets pending
        timerValue = 64'h0;
        wr(A_CTL, 32'h7);
        rd(A_CTL, 32'h5, 1'b0, "pre_disable_clear");
        timerValue = 64'hFFFF_FFFF_FFFF_FFFF;
        wr(A_CTL, 32'h0);
        rd(A_CTL, 32'h2, 1'b1, "disable_edge_set");
        rd(A_CTL, 32'h2, 1'b1, "disable_held");

        // Asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        check("async_rst_irq", 64'(timerInterrupt), 64'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        timerValue = 64'h0;
        rd(A_LO,  32'hFFFF_FFFF, 1'b0, "post_rst_lower");
        rd(A_HI,  32'hFFFF_FFFF, 1'b0, "post_rst_upper");
        rd(A_PER, 32'h0,         1'b0, "post_rst_period");
        rd(A_CTL, 32'h0,         1'b0, "post_rst_control");

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
